// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Memory-stage sequencer behind the EX/MEM pipeline register. Non-memory
// instructions pass straight through to the MEM/WB bundle in one cycle. Loads
// and stores are captured into holding registers and issued to a multi-cycle
// data memory over a req/ack handshake while the front of the pipeline is
// stalled. Store data is forwarded from WB when WB writes the register the
// store reads. A Halt instruction still retires its bundle and then parks the
// unit until reset.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   m_valid, m_in   EX bundle (49 bits) and its valid flag
//   stall_o         upstream must hold m_in/m_valid while high
//   wb_regwrite,
//   wb_wr_reg,
//   wb_data         WB-stage write port, used for store-data forwarding
//   mem_req, mem_we,
//   mem_addr,
//   mem_wdata       memory request, held stable until mem_ack
//   mem_ack,
//   mem_rdata       memory completion and read data (same cycle)
//   w_valid, w_out  registered MEM/WB bundle {result, wr_reg, RegWrite, Halt}
//   halted_o        sticky halt indicator
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [48:0] m_in,
  output logic        stall_o,
  input  logic        wb_regwrite,
  input  logic [3:0]  wb_wr_reg,
  input  logic [15:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        w_valid,
  output logic [21:0] w_out,
  output logic        halted_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBusy   = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  // EX bundle fields
  logic [3:0]  w_rr2_reg;
  logic [15:0] w_alu_result;
  logic [15:0] w_store_data;
  logic [3:0]  w_wr_reg;
  logic        w_mem_write;
  logic        w_memtoreg;
  logic        w_regwrite;
  logic        w_halt;
  logic        w_mem_read;

  assign w_rr2_reg    = m_in[44:41];
  assign w_alu_result = m_in[40:25];
  assign w_store_data = m_in[24:9];
  assign w_wr_reg     = m_in[8:5];
  assign w_mem_write  = m_in[4];
  assign w_memtoreg   = m_in[3];
  assign w_regwrite   = m_in[2];
  assign w_halt       = m_in[1];
  assign w_mem_read   = m_in[0];

  // State and holding registers
  logic [1:0]  r_state;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic [3:0]  r_wr_reg;
  logic        r_memtoreg;
  logic        r_regwrite;
  logic        r_halt;
  logic        r_w_valid;
  logic [21:0] r_w_out;

  // Next-state signals
  logic [1:0]  w_state_d;
  logic        w_capture;
  logic        w_valid_d;
  logic [21:0] w_out_d;
  logic        w_fwd;
  logic [15:0] w_wdata_sel;
  logic        w_is_mem;

  // MemRead together with MemWrite is treated as a plain store.
  assign w_is_mem = w_mem_read | w_mem_write;

  // Register 0 is hard-wired, so a WB write to it must never be forwarded.
  assign w_fwd = w_mem_write & wb_regwrite & (wb_wr_reg == w_rr2_reg) & (w_rr2_reg != 4'd0);
  assign w_wdata_sel = w_fwd ? wb_data : w_store_data;

  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    w_valid_d = 1'b0;
    w_out_d   = r_w_out;
    case (r_state)
      StIdle: begin
        if (m_valid) begin
          if (w_is_mem) begin
            w_capture = 1'b1;
            w_state_d = StBusy;
          end else begin
            w_valid_d = 1'b1;
            w_out_d   = {w_alu_result, w_wr_reg, w_regwrite, w_halt};
            w_state_d = w_halt ? StHalted : StIdle;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          w_valid_d = 1'b1;
          w_out_d   = {(r_memtoreg ? mem_rdata : r_addr), r_wr_reg, r_regwrite, r_halt};
          w_state_d = r_halt ? StHalted : StIdle;
        end
      end
      StHalted: w_state_d = StHalted;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= 16'd0;
      r_wdata    <= 16'd0;
      r_we       <= 1'b0;
      r_wr_reg   <= 4'd0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_halt     <= 1'b0;
      r_w_valid  <= 1'b0;
      r_w_out    <= 22'd0;
    end else begin
      r_state   <= w_state_d;
      r_w_valid <= w_valid_d;
      r_w_out   <= w_out_d;
      if (w_capture) begin
        r_addr     <= w_alu_result;
        r_wdata    <= w_wdata_sel;
        r_we       <= w_mem_write;
        r_wr_reg   <= w_wr_reg;
        r_memtoreg <= w_memtoreg;
        r_regwrite <= w_regwrite;
        r_halt     <= w_halt;
      end
    end
  end

  // All control outputs decode registered state only, so neither m_in nor
  // mem_ack has a combinational path to stall_o or mem_req.
  assign stall_o   = (r_state != StIdle);
  assign mem_req   = (r_state == StBusy);
  assign halted_o  = (r_state == StHalted);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign w_valid   = r_w_valid;
  assign w_out     = r_w_out;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [48:0] m_in;
  logic        stall_o;
  logic        wb_regwrite;
  logic [3:0]  wb_wr_reg;
  logic [15:0] wb_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        w_valid;
  logic [21:0] w_out;
  logic        halted_o;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .m_in        (m_in),
    .stall_o     (stall_o),
    .wb_regwrite (wb_regwrite),
    .wb_wr_reg   (wb_wr_reg),
    .wb_data     (wb_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .w_valid     (w_valid),
    .w_out       (w_out),
    .halted_o    (halted_o)
  );

  function automatic logic [48:0] mk(input logic [3:0] rr1, input logic [3:0] rr2,
                                     input logic [15:0] alu, input logic [15:0] sd,
                                     input logic [3:0] wr, input logic mw, input logic m2r,
                                     input logic rw, input logic h, input logic mr);
    return {rr1, rr2, alu, sd, wr, mw, m2r, rw, h, mr};
  endfunction

  function automatic logic [21:0] wo(input logic [15:0] res, input logic [3:0] wr,
                                     input logic rw, input logic h);
    return {res, wr, rw, h};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; m_valid = 1'b0; m_in = '0;
    wb_regwrite = 1'b0; wb_wr_reg = 4'd0; wb_data = 16'd0;
    mem_ack = 1'b0; mem_rdata = 16'd0;
    tick(); tick();

    // Reset state
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wvalid", w_valid, 0);
    chk("rst_wout", w_out, 0);
    chk("rst_halted", halted_o, 0);
    rst = 1'b0;
    tick();

    // Pass-through ADD
    m_valid = 1'b1;
    m_in = mk(4'd1, 4'd2, 16'h1234, 16'h0000, 4'd3, 0, 0, 1, 0, 0);
    tick();
    chk("add_wvalid", w_valid, 1);
    chk("add_wout", w_out, wo(16'h1234, 4'd3, 1, 0));
    chk("add_stall", stall_o, 0);
    m_valid = 1'b0;
    tick();
    chk("add_pulse", w_valid, 0);

    // Load, ack after 3 request cycles
    m_valid = 1'b1;
    m_in = mk(4'd0, 4'd0, 16'h0040, 16'h0000, 4'd5, 0, 1, 1, 0, 1);
    tick();
    m_valid = 1'b0;
    chk("ld_req1", mem_req, 1);
    chk("ld_we", mem_we, 0);
    chk("ld_addr", mem_addr, 16'h0040);
    chk("ld_stall1", stall_o, 1);
    chk("ld_wvalid1", w_valid, 0);
    tick();
    chk("ld_req2", mem_req, 1);
    chk("ld_stall2", stall_o, 1);
    tick();
    chk("ld_req3", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("ld_req_drop", mem_req, 0);
    chk("ld_stall_drop", stall_o, 0);
    chk("ld_wvalid", w_valid, 1);
    chk("ld_wout", w_out, wo(16'hBEEF, 4'd5, 1, 0));
    tick();
    chk("ld_pulse", w_valid, 0);

    // Store with WB forwarding
    m_valid = 1'b1;
    m_in = mk(4'd0, 4'd4, 16'h0080, 16'h1111, 4'd0, 1, 0, 0, 0, 0);
    wb_regwrite = 1'b1; wb_wr_reg = 4'd4; wb_data = 16'h2222;
    tick();
    m_valid = 1'b0; wb_data = 16'h3333;
    chk("st_we", mem_we, 1);
    chk("st_fwd_wdata", mem_wdata, 16'h2222);
    chk("st_addr", mem_addr, 16'h0080);
    tick();
    chk("st_wdata_stable", mem_wdata, 16'h2222);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_wvalid", w_valid, 1);
    chk("st_wout", w_out, wo(16'h0080, 4'd0, 0, 0));
    chk("st_req_drop", mem_req, 0);

    // Store from r0 (no forwarding), MemRead=MemWrite=1, minimum latency
    m_valid = 1'b1;
    m_in = mk(4'd0, 4'd0, 16'h0090, 16'h1111, 4'd0, 1, 0, 0, 0, 1);
    wb_regwrite = 1'b1; wb_wr_reg = 4'd0; wb_data = 16'h2222;
    tick();
    m_valid = 1'b0; wb_regwrite = 1'b0;
    chk("st0_wdata", mem_wdata, 16'h1111);
    chk("st0_we", mem_we, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st0_wvalid", w_valid, 1);
    chk("st0_stall", stall_o, 0);

    // Load followed by an ADD held during BUSY
    m_valid = 1'b1;
    m_in = mk(4'd0, 4'd0, 16'h0100, 16'h0000, 4'd6, 0, 1, 1, 0, 1);
    tick();
    m_in = mk(4'd0, 4'd0, 16'h0055, 16'h0000, 4'd7, 0, 0, 1, 0, 0);
    chk("hold_stall1", stall_o, 1);
    tick();
    chk("hold_wvalid_busy", w_valid, 0);
    chk("hold_addr", mem_addr, 16'h0100);
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    mem_ack = 1'b0;
    chk("hold_ld_wvalid", w_valid, 1);
    chk("hold_ld_wout", w_out, wo(16'hA5A5, 4'd6, 1, 0));
    chk("hold_stall_low", stall_o, 0);
    tick();
    m_valid = 1'b0;
    chk("hold_add_wvalid", w_valid, 1);
    chk("hold_add_wout", w_out, wo(16'h0055, 4'd7, 1, 0));
    chk("hold_add_req", mem_req, 0);
    tick();
    chk("hold_add_once", w_valid, 0);

    // Reset during BUSY with a simultaneous ack
    m_valid = 1'b1;
    m_in = mk(4'd0, 4'd0, 16'h0200, 16'h0000, 4'd2, 0, 1, 1, 0, 1);
    tick();
    m_valid = 1'b0;
    chk("rb_req", mem_req, 1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    chk("rb_req0", mem_req, 0);
    chk("rb_wvalid0", w_valid, 0);
    chk("rb_stall0", stall_o, 0);
    chk("rb_addr0", mem_addr, 0);
    chk("rb_wout0", w_out, 0);
    tick();
    chk("rb_wvalid1", w_valid, 0);

    // Halt
    m_valid = 1'b1;
    m_in = mk(4'd0, 4'd0, 16'h00AA, 16'h0000, 4'd1, 0, 0, 0, 1, 0);
    tick();
    m_in = mk(4'd0, 4'd0, 16'h0300, 16'h0000, 4'd3, 0, 1, 1, 0, 1);
    chk("halt_wvalid", w_valid, 1);
    chk("halt_wout", w_out, wo(16'h00AA, 4'd1, 0, 1));
    chk("halt_halted", halted_o, 1);
    chk("halt_stall", stall_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_no_wvalid", w_valid, 0);
      chk("halt_no_req", mem_req, 0);
      chk("halt_sticky", halted_o, 1);
    end
    m_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_halted", halted_o, 0);
    chk("halt_rst_stall", stall_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
